// File: rtl/conv_tap_engine.sv
// conv_tap_engine: serial-kernel MAC over a TAPS-sample window, block or sliding,
// with a pipelined balanced adder tree, shift/saturate output and backpressure.
module conv_tap_engine #(
  parameter int W = 16,
  parameter int TAPS = 9,
  parameter int ACC_W = 2*W+4,
  parameter int SHIFT = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mode,
  input  logic         k_load,
  input  logic [W-1:0] kernel,
  input  logic         d_valid,
  input  logic [W-1:0] data,
  output logic         d_ready,
  output logic         k_ready,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] data_out
);
  localparam int P = 1 << $clog2(TAPS);
  localparam int L = $clog2(P);
  localparam int FW = $clog2(TAPS+1);
  localparam int KW = TAPS > 1 ? $clog2(TAPS) : 1;
  localparam logic [FW-1:0] F_FULL = FW'(TAPS);
  localparam logic [FW-1:0] F_LAST = FW'(TAPS-1);
  localparam logic [KW-1:0] K_LAST = KW'(TAPS-1);
  localparam logic signed [ACC_W-1:0] HI = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LO = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [W-1:0] kreg [TAPS];
  logic signed [W-1:0] win [TAPS];
  logic signed [2*W-1:0] mul [TAPS];
  logic signed [ACC_W-1:0] prod [TAPS];
  logic signed [ACC_W-1:0] sum_q, root, sh;
  logic [W-1:0] sat;
  logic [KW-1:0] k_cnt;
  logic [FW-1:0] fill;
  logic v0, v1, v2, stall, acc, done, clr;

  assign stall = o_valid && !o_ready;
  assign d_ready = k_ready && !k_load && !stall;
  assign acc = d_valid && d_ready;
  assign done = mode ? fill >= F_LAST : fill == F_LAST;
  assign clr = k_load && k_cnt == '0;

  for (genvar i = 0; i < TAPS; i++) begin : g_mul
    assign mul[i] = win[i] * kreg[i];
  end

  // Zero-padded balanced tree; each level is its own array so no level feeds itself.
  for (genvar l = 0; l <= L; l++) begin : g_lv
    logic signed [ACC_W-1:0] s [P>>l];
    for (genvar j = 0; j < (P>>l); j++) begin : g_n
      if (l == 0 && j < TAPS) begin : g_leaf
        assign s[j] = prod[j];
      end else if (l == 0) begin : g_pad
        assign s[j] = '0;
      end else begin : g_add
        assign s[j] = g_lv[l-1].s[2*j] + g_lv[l-1].s[2*j+1];
      end
    end
  end
  assign root = g_lv[L].s[0];

  assign sh = sum_q >>> SHIFT;
  assign sat = sh > HI ? HI[W-1:0] : sh < LO ? LO[W-1:0] : sh[W-1:0];

  // Kernel loading stays live during a stall; it only touches kernel state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) kreg[i] <= '0;
      k_cnt <= '0;
      k_ready <= 1'b0;
    end else if (k_load) begin
      kreg[k_cnt] <= kernel;
      k_cnt <= k_cnt == K_LAST ? '0 : k_cnt + KW'(1);
      k_ready <= k_cnt == K_LAST ? 1'b1 : k_cnt == '0 ? 1'b0 : k_ready;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
      fill <= '0;
      v0 <= 1'b0;
    end else if (!stall) begin
      v0 <= acc && done;
      if (clr) begin
        for (int i = 0; i < TAPS; i++) win[i] <= '0;
        fill <= '0;
      end else if (acc) begin
        for (int i = TAPS-1; i > 0; i--) win[i] <= win[i-1];
        win[0] <= data;
        fill <= mode ? (fill == F_FULL ? F_FULL : fill + FW'(1)) : (done ? '0 : fill + FW'(1));
      end
    end
  end

  // Products sample the kernel at this stage, so a reload never corrupts windows in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) prod[i] <= '0;
      sum_q <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      o_valid <= 1'b0;
      data_out <= '0;
    end else if (!stall) begin
      for (int i = 0; i < TAPS; i++) prod[i] <= ACC_W'(mul[i]);
      sum_q <= root;
      v1 <= v0;
      v2 <= v1;
      o_valid <= v2;
      if (v2) data_out <= sat;
    end
  end
endmodule

// File: tb/tb_conv_tap_engine.sv
// tb_conv_tap_engine: table vectors, directed corner sequences and random traffic
// checked against a window/queue reference model (SHIFT=0 and SHIFT=4 instances).
module tb_conv_tap_engine;
  localparam int W = 16;
  localparam int TAPS = 9;

  typedef struct {
    logic md, kl;
    logic [W-1:0] kv;
    logic dv;
    logic [W-1:0] dd;
    logic ordy, er, ek, ev;
    logic [W-1:0] ed, ed2;
  } vec_t;

  logic clk = 0, rst = 0, mode = 0, k_load = 0, d_valid = 0, o_ready = 1;
  logic [W-1:0] kernel = '0, data = '0;
  logic d_ready, k_ready, o_valid, d_ready4, k_ready4, o_valid4;
  logic [W-1:0] data_out, data_out4;
  int total = 0, bad = 0;
  vec_t tv[$];
  int mk [TAPS];
  int mkc = 0;
  int hist[$], eq0[$], eq4[$], got[$];

  always #5 clk = ~clk;

  conv_tap_engine #(.W(W), .TAPS(TAPS), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .mode(mode), .k_load(k_load), .kernel(kernel),
    .d_valid(d_valid), .data(data), .d_ready(d_ready), .k_ready(k_ready),
    .o_valid(o_valid), .o_ready(o_ready), .data_out(data_out));

  conv_tap_engine #(.W(W), .TAPS(TAPS), .SHIFT(4)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .k_load(k_load), .kernel(kernel),
    .d_valid(d_valid), .data(data), .d_ready(d_ready4), .k_ready(k_ready4),
    .o_valid(o_valid4), .o_ready(o_ready), .data_out(data_out4));

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  function automatic int sv(input logic [W-1:0] x);
    return int'($signed(x));
  endfunction

  function automatic int clampv(input longint s, input int sh);
    longint v, lim;
    v = s >>> sh;
    lim = longint'(1) <<< (W-1);
    return v > lim-1 ? int'(lim-1) : v < -lim ? int'(-lim) : int'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic model_reset();
    foreach (mk[i]) mk[i] = 0;
    mkc = 0;
    hist.delete();
    eq0.delete();
    eq4.delete();
    got.delete();
  endtask

  // Called just before the active edge: scores the handshake and advances the model.
  task automatic sample();
    longint s;
    if (o_valid && o_ready) begin
      got.push_back(sv(data_out));
      if (eq0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got %0d want none", sv(data_out));
      end else begin
        chk("sb_out", sv(data_out), eq0.pop_front());
        chk("sb_out4", sv(data_out4), eq4.pop_front());
      end
    end
    if (k_load) begin
      if (mkc == 0) hist.delete();
      mk[mkc] = sv(kernel);
      mkc = (mkc + 1) % TAPS;
    end else if (d_valid && d_ready) begin
      hist.push_front(sv(data));
      if (hist.size() > TAPS) void'(hist.pop_back());
      if (hist.size() == TAPS) begin
        s = 0;
        foreach (mk[i]) s += longint'(mk[i]) * longint'(hist[i]);
        eq0.push_back(clampv(s, 0));
        eq4.push_back(clampv(s, 4));
        if (!mode) hist.delete();
      end
    end
  endtask

  task automatic step();
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic kl, input int kv, input logic dv, input int dd);
    k_load = kl;
    kernel = W'(kv);
    d_valid = dv;
    data = W'(dd);
  endtask

  task automatic load_k(input logic md, input int base, input int inc);
    mode = md;
    for (int i = 0; i < TAPS; i++) begin
      drive(1, base + inc*i, 0, 0);
      step();
    end
    k_load = 0;
  endtask

  task automatic add(input logic md, kl, input int kv, input logic dv, input int dd,
                     input logic er, ek);
    vec_t v;
    v.md = md; v.kl = kl; v.kv = W'(kv); v.dv = dv; v.dd = W'(dd); v.ordy = 1'b1;
    v.er = er; v.ek = ek; v.ev = 1'b0; v.ed = '0; v.ed2 = '0;
    tv.push_back(v);
  endtask

  task automatic want(input int i, input int d, input int d2);
    tv[i].ev = 1'b1;
    tv[i].ed = W'(d);
    tv[i].ed2 = W'(d2);
  endtask

  initial begin
    // rows 0..30: block mode, kernel 1..9, data 1..9 then nine zeros
    for (int i = 0; i < 9; i++) add(0, 1, i+1, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) add(0, 0, 0, 1, i+1, 1, 1);
    for (int i = 0; i < 9; i++) add(0, 0, 0, 1, 0, 1, 1);
    repeat (4) add(0, 0, 0, 0, 0, 1, 1);
    want(21, 165, 10);
    want(30, 0, 0);
    // rows 31..56: slide mode, kernel all 1, data 1..12
    for (int i = 0; i < 9; i++) add(1, 1, 1, 0, 0, 0, i == 0);
    for (int i = 0; i < 12; i++) add(1, 0, 0, 1, i+1, 1, 1);
    repeat (5) add(1, 0, 0, 0, 0, 1, 1);
    want(52, 45, 2); want(53, 54, 3); want(54, 63, 3); want(55, 72, 4);
    // rows 57..88: saturation in block mode
    for (int i = 0; i < 9; i++) add(0, 1, 32767, 0, 0, 0, i == 0);
    for (int i = 0; i < 9; i++) add(0, 0, 0, 1, 32767, 1, 1);
    for (int i = 0; i < 9; i++) add(0, 0, 0, 1, -32768, 1, 1);
    repeat (5) add(0, 0, 0, 0, 0, 1, 1);
    want(78, 32767, 32767);
    want(87, -32768, -32768);

    model_reset();
    #1;
    chk("rst_ov", o_valid, 0);
    chk("rst_dout", sv(data_out), 0);
    chk("rst_drdy", d_ready, 0);
    chk("rst_krdy", k_ready, 0);
    @(negedge clk);
    rst = 1;

    foreach (tv[r]) begin
      mode = tv[r].md;
      drive(tv[r].kl, sv(tv[r].kv), tv[r].dv, sv(tv[r].dd));
      o_ready = tv[r].ordy;
      #1;
      chk("tv_drdy", d_ready, tv[r].er);
      chk("tv_krdy", k_ready, tv[r].ek);
      chk("tv_ov", o_valid, tv[r].ev);
      chk("tv_ov4", o_valid4, tv[r].ev);
      chk("tv_drdy4", d_ready4 && k_ready4, tv[r].er && tv[r].ek);
      if (tv[r].ev) begin
        chk("tv_dout", sv(data_out), sv(tv[r].ed));
        chk("tv_dout4", sv(data_out4), sv(tv[r].ed2));
      end
      sample();
      @(negedge clk);
    end

    // backpressure: five stalled cycles on the first slide result
    load_k(1, 1, 0);
    got.delete();
    begin
      int n, st;
      n = 0;
      st = 0;
      for (int c = 0; c < 60 && got.size() < 4; c++) begin
        drive(0, 0, n < 12, n + 1);
        o_ready = !(o_valid && st < 5);
        #1;
        if (!o_ready) begin
          chk("bp_hold", sv(data_out), 45);
          chk("bp_ov", o_valid, 1);
          chk("bp_drdy", d_ready, 0);
          st++;
        end
        if (d_valid && d_ready) n++;
        sample();
        @(negedge clk);
      end
    end
    o_ready = 1;
    drive(0, 0, 0, 0);
    repeat (4) step();
    chk("bp_cnt", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk("bp_seq", got[i], 45 + 9*i);

    // mid-window reloads in block mode
    load_k(0, 1, 1);
    got.delete();
    for (int i = 0; i < 9; i++) begin drive(0, 0, 1, 1); step(); end
    for (int i = 0; i < 9; i++) begin
      drive(1, 2, 1, 1);
      #1;
      chk("mw_drdy", d_ready, 0);
      chk("mw_krdy", k_ready, i == 0);
      sample();
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 7); step(); end
    load_k(0, 2, 0);
    for (int i = 0; i < 9; i++) begin drive(0, 0, 1, 1); step(); end
    drive(0, 0, 0, 0);
    repeat (6) step();
    chk("mw_cnt", got.size(), 2);
    if (got.size() == 2) begin
      chk("mw_old", got[0], 45);
      chk("mw_new", got[1], 18);
    end

    // random traffic against the reference model
    for (int ph = 0; ph < 2; ph++) begin
      drive(0, 0, 0, 0);
      o_ready = 1;
      repeat (6) step();
      mode = ph[0];
      for (int i = 0; i < TAPS; i++) begin
        drive(1, ph ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 65535)), 0, 0);
        step();
      end
      for (int c = 0; c < 300; c++) begin
        drive(0, 0, $urandom_range(0, 3) != 0,
              ph ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 4095)) - 2048);
        o_ready = $urandom_range(0, 2) != 0;
        step();
      end
      drive(0, 0, 0, 0);
      o_ready = 1;
      repeat (8) step();
      chk("sb_empty", eq0.size(), 0);
    end

    // asynchronous reset in the middle of a slide stream
    load_k(1, 1, 0);
    for (int i = 0; i < 12; i++) begin drive(0, 0, 1, i+1); step(); end
    chk("pre_rst_ov", o_valid, 1);
    #2 rst = 0;
    #1;
    chk("mrst_ov", o_valid, 0);
    chk("mrst_dout", sv(data_out), 0);
    chk("mrst_drdy", d_ready, 0);
    chk("mrst_krdy", k_ready, 0);
    @(negedge clk);
    rst = 1;
    model_reset();
    mode = 0;
    for (int i = 0; i < TAPS - 1; i++) begin
      drive(1, 1, 1, 1);
      step();
      drive(0, 0, 1, 1);
      #1;
      chk("rl_drdy", d_ready, 0);
      sample();
      @(negedge clk);
    end
    drive(1, 1, 1, 1);
    step();
    drive(0, 0, 1, 1);
    #1;
    chk("rl_drdy_on", d_ready, 1);
    chk("rl_krdy_on", k_ready, 1);
    sample();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin drive(0, 0, 1, 1); step(); end
    drive(0, 0, 0, 0);
    repeat (6) step();
    chk("rl_cnt", got.size(), 1);
    chk("rl_empty", eq0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_tap_engine.md
# conv_tap_engine

Parametrised multiply-accumulate engine for one convolution output from a TAPS-element window. It loads a kernel serially, streams data samples through an internal window shift register, and produces a shifted, saturated result per window. It supports block and sliding-window modes, a pipelined adder tree and output backpressure. It sits between the pixel/line feeder and the output writer as the next-generation replacement for the fixed 9-core, ripple-summed datapath.

## Interface
- W, 16: signed data/kernel word width
- TAPS, 9: window/kernel length, 1..16
- ACC_W, 2*W+4: signed accumulator/adder-tree width; must cover TAPS products without overflow
- SHIFT, 0: arithmetic right shift applied to the sum before saturation, 0..ACC_W-W
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = block (one result per TAPS samples), 1 = slide (one result per sample once window full)
- k_load  in  1  kernel word strobe
- kernel  in  W  kernel word, signed
- d_valid  in  1  data sample valid
- data  in  W  data sample, signed
- d_ready  out  1  sample accepted when d_valid && d_ready
- k_ready  out  1  full kernel loaded
- o_valid  out  1  result valid
- o_ready  in  1  downstream accepts result
- data_out  out  W  saturated result, signed

## Operation
- Reset (async, rst low): kernel regs, window regs, fill count, k_cnt, all pipeline regs = 0; k_ready=0, d_ready=0, o_valid=0, data_out=0.
- Kernel load: each cycle with k_load=1 writes kernel into kreg[k_cnt], k_cnt++. The write with k_cnt=TAPS-1 wraps k_cnt to 0 and sets k_ready. The first word of a new load while k_ready=1 clears k_ready, clears the window regs and fill count, and writes kreg[0]. Windows already past the window register finish with the kernel values captured at their product stage.
- d_ready = k_ready && !k_load && !stall, where stall = o_valid && !o_ready. k_load wins over simultaneous d_valid, and that sample is not accepted.
- Window: on accept, shift win[i] <= win[i-1] and win[0] <= data. Newest sample is at tap 0. The first kernel word loaded multiplies tap 0.
- Fill count 0..TAPS, saturating at TAPS.
  - Block mode: a window completes on the accept that makes the count TAPS; count then resets to 0.
  - Slide mode: every accept with count already TAPS-1 or TAPS completes a window.
- A mode change is legal only while the fill count is 0; otherwise behaviour is undefined.
- Arithmetic:
  - Products are signed W×W -> 2W, sign-extended to ACC_W.
  - Balanced adder tree, registered once at the root.
  - Arithmetic shift right by SHIFT (floor).
  - Saturate to [-2^(W-1), 2^(W-1)-1].
- No internal overflow is permitted at the ACC_W default for TAPS ≤ 16.

## Timing
- Pipeline: S0 window reg (accept edge), S1 product regs, S2 tree-sum reg, S3 shift/saturate output reg.
- A window completed by an accept in cycle c drives o_valid=1 with data_out valid in cycle c+3 (accept-edge index e: output on edge e+3).
- Throughput: one result per cycle in slide mode with o_ready=1.
- Stall: while o_valid && !o_ready, all stages S0–S3 freeze and data_out/o_valid hold. d_ready=0. k_load is still accepted and changes only kreg, k_cnt and k_ready.
- o_valid drops the cycle after a handshake if no new result is in S2. Bubbles are not compressed.
- Reset mid-operation discards all in-flight windows; o_valid is 0 immediately (async).

## Test plan
- Reset: assert rst=0 mid-stream -> o_valid=0, data_out=0, d_ready=0, k_ready=0 immediately; after release d_ready stays 0 until 9 kernel words are loaded.
- Block mode, TAPS=9: kernel 1..9, data 1..9 back-to-back -> single result data_out=165, o_valid exactly 3 cycles after the 9th accept; next 9 samples all 0 -> 0.
- Slide mode: kernel all 1, data 1..12 -> results 45, 54, 63, 72 on consecutive cycles, first 3 cycles after the 9th accept.
- Saturation: kernel all 32767 with data all 32767 -> 32767; data all -32768 -> -32768. SHIFT=4 with the 165 case -> 10.
- Backpressure: hold o_ready=0 for 5 cycles during the slide stream -> data_out/o_valid frozen, d_ready=0, no result lost or duplicated, sequence resumes in order.
- Mid-window reload: block mode, 4 samples in, then load kernel all 2 -> k_ready low during load, fill cleared. A window already in S1 completes with the old kernel. 9 new samples of 1 -> 18.
